// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Saturation on signed overflow is enabled with SERIAL_ARITH_SAT_EN.
package serial_arith_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Flags captured alongside the parallel result.
  typedef struct packed {
    logic carry;
    logic ovf;
    logic len_err;
  } flags_t;

  // Counter must reach WIDTH itself, hence the +1.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  // MSB of the saturated result; the remaining bits are its complement.
  localparam logic SAT_POS_MSB = 1'b0;
  localparam logic SAT_NEG_MSB = 1'b1;

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder with registered carry, B inversion and carry preset.
// Exposes the carry-in and carry-out used by the current bit for overflow detection.
module serial_fa_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic preset,
  input  logic preset_val,
  input  logic a,
  input  logic b,
  input  logic inv,
  output logic s,
  output logic cin,
  output logic cout
);

  logic c_q;
  logic bb;

  // On the first beat of a packet the stored carry is stale, so the preset wins.
  assign cin  = preset ? preset_val : c_q;
  assign bb   = b ^ inv;
  assign s    = a ^ bb ^ cin;
  assign cout = (a & bb) | (cin & (a ^ bb));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    c_q <= 1'b0;
    else if (en) c_q <= cout;
  end

endmodule

// File: rtl/serial_arith_with_vld.sv
// Bit-serial add/sub, LSB first, with parallel result, carry, overflow and length-error flags.
// Define SERIAL_ARITH_SAT_EN to saturate full-width overflowing results.
module serial_arith_with_vld
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld,
  input  logic             a,
  input  logic             b,
  input  logic             sub,
  input  logic             last,
  output logic [WIDTH-1:0] sum,
  output logic             sum_vld,
  output logic             carry_out,
  output logic             overflow,
  output logic             len_err
);

  localparam int              CNT_W   = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             mode;
  logic [WIDTH-1:0] acc;
  logic             len_pend;
  logic             cin_q, cout_q;

  logic             first, take, over, done;
  logic             fa_s, fa_cin, fa_cout;
  logic [CNT_W-1:0] pos, cnt_nx;
  logic [WIDTH-1:0] acc_nx, res;
  logic             cin_nx, cout_nx, len_nx;
  flags_t           flg_nx;

  assign first = vld && (state == IDLE);
  assign take  = first || (vld && (state == RUN) && (cnt < CNT_MAX));
  assign over  = vld && (state == RUN) && (cnt >= CNT_MAX);
  assign done  = vld && last;

  serial_fa_cell u_fa (
    .clk        (clk),
    .rst        (rst),
    .en         (take),
    .preset     (first),
    .preset_val (sub),
    .a          (a),
    .b          (b),
    .inv        (first ? sub : mode),
    .s          (fa_s),
    .cin        (fa_cin),
    .cout       (fa_cout)
  );

`ifdef SERIAL_ARITH_SAT_EN
  logic a_q, a_nx;
`endif

  // Next-state view of the packet, so completion can register it in the same edge.
  always_comb begin
    pos     = first ? '0 : cnt;
    acc_nx  = first ? '0 : acc;
    for (int i = 0; i < WIDTH; i++)
      if (take && (CNT_W'(i) == pos)) acc_nx[i] = fa_s;
    cnt_nx  = take ? pos + CNT_W'(1) : cnt;
    cin_nx  = take ? fa_cin  : cin_q;
    cout_nx = take ? fa_cout : cout_q;
    len_nx  = first ? 1'b0 : (len_pend | over);
    flg_nx.carry   = cout_nx;
    flg_nx.ovf     = (first && last) ? 1'b0 : (cin_nx ^ cout_nx);
    flg_nx.len_err = len_nx;
    res = acc_nx;
`ifdef SERIAL_ARITH_SAT_EN
    a_nx = take ? a : a_q;
    if (flg_nx.ovf && (cnt_nx == CNT_MAX))
      res = a_nx ? {SAT_NEG_MSB, {(WIDTH-1){~SAT_NEG_MSB}}}
                 : {SAT_POS_MSB, {(WIDTH-1){~SAT_POS_MSB}}};
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mode      <= 1'b0;
      acc       <= '0;
      len_pend  <= 1'b0;
      cin_q     <= 1'b0;
      cout_q    <= 1'b0;
`ifdef SERIAL_ARITH_SAT_EN
      a_q       <= 1'b0;
`endif
      sum       <= '0;
      sum_vld   <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      sum_vld <= done;
      if (vld) begin
        cnt      <= cnt_nx;
        acc      <= acc_nx;
        len_pend <= len_nx;
        cin_q    <= cin_nx;
        cout_q   <= cout_nx;
`ifdef SERIAL_ARITH_SAT_EN
        a_q      <= a_nx;
`endif
        if (first) mode <= sub;
      end
      case (state)
        IDLE: if (vld && !last) state <= RUN;
        RUN:  if (vld && last)  state <= IDLE;
        default: state <= IDLE;
      endcase
      if (done) begin
        sum       <= res;
        carry_out <= flg_nx.carry;
        overflow  <= flg_nx.ovf;
        len_err   <= flg_nx.len_err;
      end
    end
  end

endmodule

// File: tb/tb_serial_arith_with_vld.sv
// Directed, table-driven bench for serial_arith_with_vld at WIDTH=8.
module tb_serial_arith_with_vld;

`ifdef SERIAL_ARITH_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vld = 1'b0, a = 1'b0, b = 1'b0, sub = 1'b0, last = 1'b0;
  logic [7:0] sum;
  logic       sum_vld, carry_out, overflow, len_err;

  serial_arith_with_vld #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .vld(vld), .a(a), .b(b), .sub(sub), .last(last),
    .sum(sum), .sum_vld(sum_vld), .carry_out(carry_out),
    .overflow(overflow), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic        sub;
    int          n;
    logic        gap;
    logic [7:0]  sum;
    logic        c, ov, le;
  } vec_t;

  vec_t       vt[14];
  int         total = 0, passed = 0;
  int         strobes = 0;
  logic [7:0] cap_q[$];

  always @(negedge clk)
    if (rst && sum_vld) begin
      strobes++;
      cap_q.push_back(sum);
    end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d] got %0h want %0h", nm, idx, act, exp);
  endtask

  function automatic vec_t mk(input logic [15:0] va, vb, input logic vs, input int vn,
                              input logic vg, input logic [7:0] es, input logic ec, eo, el);
    vec_t v;
    v.a = va; v.b = vb; v.sub = vs; v.n = vn; v.gap = vg;
    v.sum = es; v.c = ec; v.ov = eo; v.le = el;
    return v;
  endfunction

  // Later beats drive the opposite sub value, which must be ignored.
  task automatic drive_pkt(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      vld = 1'b1; a = v.a[i]; b = v.b[i];
      sub = (i == 0) ? v.sub : ~v.sub;
      last = (i == v.n - 1);
      if (v.gap && i != v.n - 1) begin
        @(negedge clk);
        vld = 1'b0; last = 1'b1; a = 1'($urandom); b = 1'($urandom); sub = 1'($urandom);
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int base;
    base = strobes;
    drive_pkt(v);
    @(negedge clk);
    vld = 1'b0; last = 1'b0;
    #1;
    chk("sum_vld_hi", idx, 32'(sum_vld), 32'd1);
    chk("sum", idx, 32'(sum), 32'(v.sum));
    chk("carry_out", idx, 32'(carry_out), 32'(v.c));
    chk("overflow", idx, 32'(overflow), 32'(v.ov));
    chk("len_err", idx, 32'(len_err), 32'(v.le));
    @(negedge clk);
    #1;
    chk("sum_vld_lo", idx, 32'(sum_vld), 32'd0);
    chk("strobe_cnt", idx, 32'(strobes - base), 32'd1);
    chk("sum_hold", idx, 32'(sum), 32'(v.sum));
  endtask

  initial begin
    int base;
    vt[0]  = mk(16'd5,     16'd3,     1'b0, 8,  1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
    vt[1]  = mk(16'd3,     16'd5,     1'b1, 8,  1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
    vt[2]  = mk(16'd5,     16'd3,     1'b1, 8,  1'b0, 8'h02, 1'b1, 1'b0, 1'b0);
    vt[3]  = mk(16'd100,   16'd50,    1'b0, 8,  1'b0, SAT ? 8'h7F : 8'h96, 1'b0, 1'b1, 1'b0);
    vt[4]  = mk(16'h000F,  16'h0001,  1'b0, 4,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vt[5]  = mk(16'h0301,  16'h0001,  1'b0, 10, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
    vt[6]  = mk(16'h0012,  16'h0034,  1'b0, 8,  1'b0, 8'h46, 1'b0, 1'b0, 1'b0);
    vt[7]  = mk(16'd5,     16'd3,     1'b0, 8,  1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
    vt[8]  = mk(16'h0001,  16'h0001,  1'b0, 1,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vt[9]  = mk(16'h0000,  16'h0001,  1'b1, 1,  1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
    vt[10] = mk(16'h0080,  16'h0001,  1'b1, 8,  1'b0, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1, 1'b0);
    vt[11] = mk(16'h0080,  16'h0080,  1'b0, 8,  1'b0, SAT ? 8'h80 : 8'h00, 1'b1, 1'b1, 1'b0);
    vt[12] = mk(16'h007F,  16'h0001,  1'b0, 8,  1'b1, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1, 1'b0);
    vt[13] = mk(16'h0003,  16'h0005,  1'b1, 4,  1'b0, 8'h0E, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_sum", 0, 32'(sum), 32'd0);
    chk("rst_sum_vld", 0, 32'(sum_vld), 32'd0);
    chk("rst_carry", 0, 32'(carry_out), 32'd0);
    chk("rst_ovf", 0, 32'(overflow), 32'd0);
    chk("rst_len_err", 0, 32'(len_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vt[i], i);

    // Back-to-back packets: second first-beat shares the cycle with the first strobe.
    base = strobes;
    cap_q.delete();
    drive_pkt(vt[0]);
    drive_pkt(vt[6]);
    @(negedge clk);
    vld = 1'b0; last = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("b2b_strobes", 0, 32'(strobes - base), 32'd2);
    chk("b2b_sum0", 0, (cap_q.size() > 0) ? 32'(cap_q[0]) : 32'hDEAD, 32'h08);
    chk("b2b_sum1", 0, (cap_q.size() > 1) ? 32'(cap_q[1]) : 32'hDEAD, 32'h46);

    // Reset in the middle of a packet after four beats.
    base = strobes;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vld = 1'b1; a = vt[6].a[i]; b = vt[6].b[i]; sub = 1'b0; last = 1'b0;
    end
    @(negedge clk);
    vld = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_sum", 0, 32'(sum), 32'd0);
    chk("mid_rst_carry", 0, 32'(carry_out), 32'd0);
    chk("mid_rst_sum_vld", 0, 32'(sum_vld), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("mid_rst_no_strobe", 0, 32'(strobes - base), 32'd0);
    run_vec(vt[2], 100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
